// File: rtl/spi_trim_pkg.sv
// Shared types and constants for the SPI trim register bank.
//   state_t        : frame FSM states
//   CMD_W / ADDR_W : command byte width and register pointer width
//   RW_BIT         : command bit selecting write (1) or read (0)
//   addr_in_range  : true when a pointer addresses an implemented register
package spi_trim_pkg;

   localparam int unsigned CMD_W  = 8;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned RW_BIT = 7;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA
   } state_t;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a,
                                          input int unsigned       nregs);
      return 32'(a) < nregs;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   sync     : synchronised level
//   rise     : one-cycle pulse, 3 clk after a rising pin edge
//   fall     : one-cycle pulse, 3 clk after a falling pin edge
module spi_sync_edge #(
   parameter logic RST_LVL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= RST_LVL;
         sync   <= RST_LVL;
         sync_q <= RST_LVL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         meta   <= d;
         sync   <= meta;
         sync_q <= sync;
         rise   <= sync & ~sync_q;
         fall   <= ~sync & sync_q;
      end
   end

endmodule

// File: rtl/spi_trim_bank.sv
// Parametrised SPI trim register bank (mode 0, MSB first).
// Frame: command byte {rw, addr[6:0]} followed by REG_W-bit data words,
// pointer auto-increments after each word.
// Optional feature macro: SPI_TRIM_SHADOW_EN -- writes land in shadows and
// are committed to o_trim together one clk after cs_n rises internally.
//   clk, rst        : system clock, synchronous active-high reset
//   i_sclk, i_cs_n  : SPI clock / chip select (asynchronous)
//   i_mosi          : SPI data in (asynchronous)
//   o_miso          : SPI data out, changes after sclk fall
//   o_miso_oe       : high while synchronised cs_n is low
//   o_addr          : current register pointer
//   o_trim          : flat trim bus, register k at [k*REG_W +: REG_W]
//   o_busy          : high while in CMD or DATA
module spi_trim_bank
   import spi_trim_pkg::*;
#(
   parameter int unsigned      NREGS   = 8,
   parameter int unsigned      REG_W   = 8,
   parameter logic [REG_W-1:0] RST_VAL = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_sclk,
   input  logic                   i_cs_n,
   input  logic                   i_mosi,
   output logic                   o_miso,
   output logic                   o_miso_oe,
   output logic [ADDR_W-1:0]      o_addr,
   output logic [NREGS*REG_W-1:0] o_trim,
   output logic                   o_busy
);

   localparam int unsigned SR_W      = (REG_W > CMD_W) ? REG_W : CMD_W;
   localparam int unsigned BIT_CNT_W = 6;

   state_t state;
   state_t state_next;

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_m, mosi_s;

   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [SR_W-2:0]      rx_sr;
   logic [SR_W-1:0]      rx_next;
   logic [REG_W-1:0]     tx_sr;
   logic                 is_wr;

   logic bit_rise, bit_fall;
   logic cmd_done, word_done;
   logic busy_c;

   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_rw;
   logic [REG_W-1:0]  word_c;
   logic [ADDR_W-1:0] addr_inc_c;
   logic [REG_W-1:0]  rd_cmd_c;
   logic [REG_W-1:0]  rd_next_c;

`ifdef SPI_TRIM_SHADOW_EN
   logic [NREGS*REG_W-1:0] shadow;
   logic [NREGS-1:0]       dirty;
`endif

   spi_sync_edge #(.RST_LVL(1'b0)) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (i_sclk),
      .sync (sclk_s),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync_edge #(.RST_LVL(1'b1)) u_cs_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (i_cs_n),
      .sync (cs_s),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   // MOSI needs only the level synchroniser
   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_m <= 1'b0;
         mosi_s <= 1'b0;
      end else begin
         mosi_m <= i_mosi;
         mosi_s <= mosi_m;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // FSM next state; deasserted chip select wins from any state
   always_comb begin
      state_next = state;
      if (cs_s || cs_rise) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (cs_fall) state_next = CMD;
            CMD:     if (cmd_done) state_next = DATA;
            DATA:    state_next = DATA;
            default: state_next = IDLE;
         endcase
      end
   end

   // FSM decode; edges are qualified by the level to reject one-cycle glitches
   always_comb begin
      bit_rise  = sclk_rise & sclk_s;
      bit_fall  = sclk_fall & ~sclk_s;
      cmd_done  = (state == CMD)  && !cs_s && bit_rise
                  && (bit_cnt == BIT_CNT_W'(CMD_W - 1));
      word_done = (state == DATA) && !cs_s && bit_rise
                  && (bit_cnt == BIT_CNT_W'(REG_W - 1));
      busy_c    = (state_next != IDLE);
   end

   // Datapath decode: incoming word/command, pointer increment, read muxes
   always_comb begin
      rx_next  = {rx_sr, mosi_s};
      word_c   = rx_next[REG_W-1:0];
      cmd_addr = rx_next[ADDR_W-1:0];
      cmd_rw   = rx_next[RW_BIT];

      // in-range pointers wrap at NREGS, out-of-range ones at 2^ADDR_W
      if (addr_in_range(o_addr, NREGS) && (32'(o_addr) + 32'd1 == NREGS))
         addr_inc_c = '0;
      else
         addr_inc_c = o_addr + ADDR_W'(1);

      // unmatched (out-of-range) addresses read as zero
      rd_cmd_c  = '0;
      rd_next_c = '0;
      for (int unsigned k = 0; k < NREGS; k++) begin
         if (32'(cmd_addr) == k)   rd_cmd_c  = o_trim[k*REG_W +: REG_W];
         if (32'(addr_inc_c) == k) rd_next_c = o_trim[k*REG_W +: REG_W];
      end
   end

   // Shift registers, pointer, trim storage and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         is_wr     <= 1'b0;
         o_addr    <= '0;
         o_miso    <= 1'b0;
         o_miso_oe <= 1'b0;
         o_busy    <= 1'b0;
         o_trim    <= {NREGS{RST_VAL}};
`ifdef SPI_TRIM_SHADOW_EN
         shadow    <= {NREGS{RST_VAL}};
         dirty     <= '0;
`endif
      end else begin
         o_busy    <= busy_c;
         o_miso_oe <= ~cs_s;

         if (state_next == IDLE || cmd_done || word_done)
            bit_cnt <= '0;
         else if (bit_rise)
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);

         if (bit_rise) rx_sr <= rx_next[SR_W-2:0];

         if (cmd_done) begin
            o_addr <= cmd_addr;
            is_wr  <= cmd_rw;
            tx_sr  <= rd_cmd_c;
         end else if (word_done) begin
            o_addr <= addr_inc_c;
            if (!is_wr) tx_sr <= rd_next_c;
         end else if (bit_fall && state == DATA && !is_wr) begin
            tx_sr <= tx_sr << 1;
         end

         if (state_next != DATA || is_wr)
            o_miso <= 1'b0;
         else if (bit_fall)
            o_miso <= tx_sr[REG_W-1];

`ifdef SPI_TRIM_SHADOW_EN
         if (word_done && is_wr) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
               if (32'(o_addr) == k) begin
                  shadow[k*REG_W +: REG_W] <= word_c;
                  dirty[k]                 <= 1'b1;
               end
            end
         end
         // atomic commit of everything written during the frame
         if (cs_rise) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
               if (dirty[k]) o_trim[k*REG_W +: REG_W] <= shadow[k*REG_W +: REG_W];
            end
            dirty <= '0;
         end
`else
         if (word_done && is_wr) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
               if (32'(o_addr) == k) o_trim[k*REG_W +: REG_W] <= word_c;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_spi_trim_bank.sv
// Self-checking bench for spi_trim_bank (NREGS=8, REG_W=8, RST_VAL=8'h5A).
// Optional macro SPI_TRIM_SHADOW_EN selects the shadow-commit checks.
module tb_spi_trim_bank;

   localparam int unsigned NREGS = 8;
   localparam int unsigned REG_W = 8;
   localparam logic [7:0]  RST_V = 8'h5A;
   localparam int          HALF  = 8;
   localparam int          CSS   = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic        miso_oe;
   logic        busy;
   logic [6:0]  addr;
   logic [63:0] trim;

   int n_checks = 0;
   int n_fail   = 0;

   logic tx_q[$];
   logic rx_q[$];

   typedef struct {
      logic [7:0]  cmd;
      int          n;
      logic [23:0] d;
      logic [63:0] exp_trim;
      logic [6:0]  exp_addr;
   } vec_t;

   vec_t        vecs[7];
   logic [23:0] dd;
   logic [63:0] old_trim;
   logic        rx_or;

   always #5 clk = ~clk;

   spi_trim_bank #(
      .NREGS   (NREGS),
      .REG_W   (REG_W),
      .RST_VAL (RST_V)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_sclk    (sclk),
      .i_cs_n    (cs_n),
      .i_mosi    (mosi),
      .o_miso    (miso),
      .o_miso_oe (miso_oe),
      .o_addr    (addr),
      .o_trim    (trim),
      .o_busy    (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) tx_q.push_back(b[i]);
   endtask

   task automatic frame_start();
      rx_q.delete();
      cs_n = 1'b0;
      wait_clk(CSS);
      check("busy_in_frame", 64'(busy), 64'd1);
      check("oe_in_frame", 64'(miso_oe), 64'd1);
   endtask

   // mosi set while sclk low; miso sampled just before each rising edge
   task automatic frame_bits();
      while (tx_q.size() > 0) begin
         mosi = tx_q.pop_front();
         wait_clk(HALF);
         rx_q.push_back(miso);
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic frame_end();
      wait_clk(CSS);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(10);
      check("busy_after_frame", 64'(busy), 64'd0);
      check("oe_after_frame", 64'(miso_oe), 64'd0);
      check("miso_after_frame", 64'(miso), 64'd0);
   endtask

   task automatic run_frame();
      frame_start();
      frame_bits();
      frame_end();
   endtask

   function automatic logic [7:0] rx_word(input int k);
      logic [7:0] w = '0;
      for (int i = 0; i < 8; i++) w = {w[6:0], rx_q[8 + 8*k + i]};
      return w;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h86, 3, 24'h112233, 64'h22115A5A5A5A5A33, 7'd1};
      vecs[1] = '{8'h83, 1, 24'hC30000, 64'h22115A5AC35A5A33, 7'd4};
      vecs[2] = '{8'h84, 1, 24'h440000, 64'h22115A44C35A5A33, 7'd5};
      vecs[3] = '{8'hFF, 1, 24'hAA0000, 64'h22115A44C35A5A33, 7'd0};
      vecs[4] = '{8'h81, 2, 24'h010200, 64'h22115A44C3020133, 7'd3};
      vecs[5] = '{8'h80, 0, 24'h000000, 64'h22115A44C3020133, 7'd0};
      vecs[6] = '{8'h85, 3, 24'h556677, 64'h77665544C3020133, 7'd0};

      // reset
      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      wait_clk(5);
      check("rst_trim", trim, 64'h5A5A5A5A5A5A5A5A);
      rst = 1'b0;
      wait_clk(10);
      check("rst_trim_held", trim, 64'h5A5A5A5A5A5A5A5A);
      check("rst_addr", 64'(addr), 64'd0);
      check("rst_miso", 64'(miso), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_oe", 64'(miso_oe), 64'd0);

      // table of write frames
      for (int v = 0; v < 7; v++) begin
         tx_q.delete();
         push_byte(vecs[v].cmd);
         dd = vecs[v].d;
         for (int j = 0; j < vecs[v].n; j++) begin
            push_byte(dd[23:16]);
            dd = dd << 8;
         end
         run_frame();
         check($sformatf("vec%0d_trim", v), trim, vecs[v].exp_trim);
         check($sformatf("vec%0d_addr", v), 64'(addr), 64'(vecs[v].exp_addr));
         rx_or = 1'b0;
         foreach (rx_q[i]) rx_or |= rx_q[i];
         check($sformatf("vec%0d_miso_quiet", v), 64'(rx_or), 64'd0);
      end

      // readback of reg3 then reg4
      push_byte(8'h03); push_byte(8'h00); push_byte(8'h00);
      run_frame();
      check("rd_word0", 64'(rx_word(0)), 64'hC3);
      check("rd_word1", 64'(rx_word(1)), 64'h44);
      check("rd_addr", 64'(addr), 64'd5);
      check("rd_no_modify", trim, 64'h77665544C3020133);

      // out-of-range read
      push_byte(8'h7F); push_byte(8'h00);
      run_frame();
      check("oor_rd_word", 64'(rx_word(0)), 64'h00);
      check("oor_rd_addr", 64'(addr), 64'd0);
      check("oor_rd_trim", trim, 64'h77665544C3020133);

      // abort mid-word, then a normal frame
      push_byte(8'h82);
      tx_q.push_back(1'b1); tx_q.push_back(1'b0); tx_q.push_back(1'b1);
      tx_q.push_back(1'b0); tx_q.push_back(1'b1);
      run_frame();
      check("abort_trim", trim, 64'h77665544C3020133);
      check("abort_addr", 64'(addr), 64'd2);
      push_byte(8'h82); push_byte(8'h9C);
      run_frame();
      check("post_abort_trim", trim, 64'h77665544C39C0133);
      check("post_abort_addr", 64'(addr), 64'd3);

      // two-word frame: commit timing depends on the build
      frame_start();
      push_byte(8'h80); push_byte(8'hA1); push_byte(8'hA2);
      frame_bits();
`ifdef SPI_TRIM_SHADOW_EN
      wait_clk(CSS);
      check("shadow_hold", trim, 64'h77665544C39C0133);
      old_trim = trim;
      cs_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         wait_clk(1);
         if (trim !== old_trim) break;
      end
      check("shadow_commit", trim, 64'h77665544C39CA2A1);
      wait_clk(10);
      check("shadow_busy", 64'(busy), 64'd0);
`else
      check("direct_write", trim, 64'h77665544C39CA2A1);
      frame_end();
`endif
      check("two_word_addr", 64'(addr), 64'd2);

      // reset mid-frame, released after cs_n goes high
      frame_start();
      push_byte(8'h80); push_byte(8'hB0);
      frame_bits();
      rst = 1'b1;
      wait_clk(3);
      cs_n = 1'b1;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(10);
      check("rst_mid_trim", trim, 64'h5A5A5A5A5A5A5A5A);
      check("rst_mid_addr", 64'(addr), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      push_byte(8'h87); push_byte(8'hE7);
      run_frame();
      check("post_rst_trim", trim, 64'hE75A5A5A5A5A5A5A);
      check("post_rst_addr", 64'(addr), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
